// File: rtl/alu_if.sv
// Operand/opcode/result bundle for the single-cycle ALU.
// The ALU drives the two result words; the requester drives everything else.
interface alu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  opcode;
  logic [31:0] Zlowout;
  logic [31:0] Zhighout;

  modport master (output A, B, opcode, input Zlowout, Zhighout);
  modport slave  (input A, B, opcode, output Zlowout, Zhighout);
endinterface

// File: rtl/alu.sv
// 32-bit single-cycle ALU with registered 64-bit {high, low} result.
// Every operation is combinational and is captured on the next rising clock.
module alu (
  input  logic  clock,
  input  logic  clear,
  alu_if.slave  bus
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SHR  = 5'd4,
    OP_SHRA = 5'd5,
    OP_SHL  = 5'd6,
    OP_ROR  = 5'd7,
    OP_ROL  = 5'd8,
    OP_NEG  = 5'd9,
    OP_MUL  = 5'd10,
    OP_DIV  = 5'd11,
    OP_NOT  = 5'd12
  } op_t;

  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  amt;

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;

  logic [63:0] ror_wide;
  logic [63:0] rol_wide;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quotient;
  logic [31:0] remainder;

  logic [31:0] lo_next;
  logic [31:0] hi_next;
  logic [31:0] lo_q;
  logic [31:0] hi_q;

  assign a   = bus.A;
  assign b   = bus.B;
  assign amt = bus.B[4:0];

  // Sign-extend to 64 bits so the product is the full signed 64-bit result.
  assign a_ext   = {{32{a[31]}}, a};
  assign b_ext   = {{32{b[31]}}, b};
  assign product = a_ext * b_ext;

  assign ror_wide = {a, a} >> amt;
  assign rol_wide = {a, a} << amt;

  // Magnitude division avoids signed-overflow corner cases; 0x80000000 / -1
  // falls out as 0x80000000 remainder 0 after the sign fix-up.
  assign a_mag     = a[31] ? (32'd0 - a) : a;
  assign b_mag     = b[31] ? (32'd0 - b) : b;
  assign b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag     = a_mag / b_div;
  assign r_mag     = a_mag % b_div;
  assign quotient  = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
  assign remainder = a[31] ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    lo_next = 32'd0;
    hi_next = 32'd0;
    case (bus.opcode)
      OP_ADD:  lo_next = a + b;
      OP_SUB:  lo_next = a - b;
      OP_AND:  lo_next = a & b;
      OP_OR:   lo_next = a | b;
      OP_SHR:  lo_next = a >> amt;
      OP_SHRA: lo_next = $unsigned($signed(a) >>> amt);
      OP_SHL:  lo_next = a << amt;
      OP_ROR:  lo_next = ror_wide[31:0];
      OP_ROL:  lo_next = rol_wide[63:32];
      OP_NEG:  lo_next = 32'd0 - a;
      OP_MUL: begin
        lo_next = product[31:0];
        hi_next = product[63:32];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          lo_next = 32'hFFFF_FFFF;
          hi_next = a;
        end else begin
          lo_next = quotient;
          hi_next = remainder;
        end
      end
      OP_NOT:  lo_next = ~a;
      default: begin
        lo_next = 32'd0;
        hi_next = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      lo_q <= 32'd0;
      hi_q <= 32'd0;
    end else begin
      lo_q <= lo_next;
      hi_q <= hi_next;
    end
  end

  assign bus.Zlowout  = lo_q;
  assign bus.Zhighout = hi_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vectors from the requirement list, reset behaviour,
// then random operations checked against a plain-arithmetic reference model.
module tb_alu;
  logic clock;
  logic clear;
  int   total;
  int   bad;

  alu_if bus ();

  alu dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: 64-bit integer arithmetic straight from the operation rules.
  function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          p;
    int              n;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    n  = {27'd0, b[4:0]};
    lo = 32'd0;
    hi = 32'd0;
    case (op)
      5'd0:  lo = 32'(ua + ub);
      5'd1:  lo = 32'(ua - ub);
      5'd2:  lo = a & b;
      5'd3:  lo = a | b;
      5'd4:  lo = 32'(ua >> n);
      5'd5:  lo = 32'(sa >>> n);
      5'd6:  lo = 32'(ua << n);
      5'd7:  lo = 32'((ua >> n) | (ua << (32 - n)));
      5'd8:  lo = 32'((ua << n) | (ua >> (32 - n)));
      5'd9:  lo = 32'(64'd0 - ua);
      5'd10: begin
        p  = sa * sb;
        lo = p[31:0];
        hi = p[63:32];
      end
      5'd11: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
      end
      5'd12: lo = ~a;
      default: begin
        lo = 32'd0;
        hi = 32'd0;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge load, sample 1 ns later.
  task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.opcode = op;
    bus.A      = a;
    bus.B      = b;
    @(posedge clock);
    #1;
  endtask

  task automatic directed(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    apply(op, a, b);
    check({tag, "_lo"}, bus.Zlowout, exp_lo);
    check({tag, "_hi"}, bus.Zhighout, exp_hi);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rop;
    logic [31:0] m_lo;
    logic [31:0] m_hi;
    total      = 0;
    bad        = 0;
    clear      = 1'b0;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    bus.opcode = 5'd0;

    #2;
    check("reset_lo", bus.Zlowout, 32'd0);
    check("reset_hi", bus.Zhighout, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    directed("add",  5'd0, 32'hFFFF_FFF9, 32'd10,  32'h0000_0003, 32'd0);
    directed("sub",  5'd1, 32'h0000_03FF, 32'h2AA, 32'h0000_0155, 32'd0);
    directed("and",  5'd2, 32'h0000_03FF, 32'h2AA, 32'h0000_02AA, 32'd0);
    directed("or",   5'd3, 32'h0000_03FF, 32'd5,   32'h0000_03FF, 32'd0);

    for (int rep = 0; rep < 2; rep++) begin
      logic [31:0] amt;
      amt = (rep == 0) ? 32'd5 : 32'h25;
      directed("shr",  5'd4, 32'hFFFF_FFFB, amt, 32'h07FF_FFFF, 32'd0);
      directed("shra", 5'd5, 32'hFFFF_FFFB, amt, 32'hFFFF_FFFF, 32'd0);
      directed("shl",  5'd6, 32'hFFFF_FFFB, amt, 32'hFFFF_FF60, 32'd0);
      directed("ror",  5'd7, 32'hFFFF_FFFB, amt, 32'hDFFF_FFFF, 32'd0);
      directed("rol",  5'd8, 32'hFFFF_FFFB, amt, 32'hFFFF_FF7F, 32'd0);
    end
    directed("ror_zero", 5'd7, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 32'd0);
    directed("shra_pos", 5'd5, 32'h4000_0000, 32'd4, 32'h0400_0000, 32'd0);

    directed("neg",  5'd9,  32'd30, 32'd77, 32'hFFFF_FFE2, 32'd0);
    directed("not",  5'd12, 32'd30, 32'd0,  32'hFFFF_FFE1, 32'd0);
    directed("mul1", 5'd10, 32'd5,  32'd5,  32'd25, 32'd0);
    directed("mul2", 5'd10, 32'd5,  32'hFFFF_FFEF, 32'hFFFF_FFAB, 32'hFFFF_FFFF);
    directed("div1", 5'd11, 32'd25, 32'd8,  32'd3, 32'd1);
    directed("div2", 5'd11, 32'd30, 32'd9,  32'd3, 32'd3);
    directed("div3", 5'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    directed("div4", 5'd11, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    directed("div0", 5'd11, 32'd25, 32'd0,  32'hFFFF_FFFF, 32'd25);
    directed("divov", 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    directed("add_ovf", 5'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0);
    directed("op20", 5'd20, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 32'd0);

    // Asynchronous clear mid-cycle, hold through an edge, then release.
    directed("rst_pre", 5'd10, 32'd5, 32'hFFFF_FFEF, 32'hFFFF_FFAB, 32'hFFFF_FFFF);
    #2;
    clear = 1'b0;
    #1;
    check("rst_async_lo", bus.Zlowout, 32'd0);
    check("rst_async_hi", bus.Zhighout, 32'd0);
    @(posedge clock);
    #1;
    check("rst_hold_lo", bus.Zlowout, 32'd0);
    check("rst_hold_hi", bus.Zhighout, 32'd0);
    @(negedge clock);
    clear      = 1'b1;
    bus.opcode = 5'd0;
    bus.A      = 32'd1;
    bus.B      = 32'd1;
    @(posedge clock);
    #1;
    check("rst_release_lo", bus.Zlowout, 32'd2);
    check("rst_release_hi", bus.Zhighout, 32'd0);
    directed("op20b", 5'd20, 32'd5, 32'd5, 32'd0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 5'($urandom_range(0, 15));
      if (i % 7 == 0) rb = 32'($urandom_range(0, 3)) - 32'd1;
      if (i % 11 == 0) ra = 32'h8000_0000;
      if (i % 13 == 0) rb = 32'd0;
      model(rop, ra, rb, m_lo, m_hi);
      apply(rop, ra, rb);
      check($sformatf("rnd%0d_op%0d_lo", i, rop), bus.Zlowout, m_lo);
      check($sformatf("rnd%0d_op%0d_hi", i, rop), bus.Zhighout, m_hi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end
endmodule
